// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: shared op, state and fault encodings for the program-counter sequencer
package pc_pkg;
    typedef enum logic [2:0] {
        OP_NEXT    = 3'd0,
        OP_BR_REL  = 3'd1,
        OP_JMP_ABS = 3'd2,
        OP_CALL    = 3'd3,
        OP_RET     = 3'd4,
        OP_HALT    = 3'd5
    } pc_op_t;
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } pc_state_t;
    typedef enum logic [1:0] {
        FLT_NONE      = 2'd0,
        FLT_OVERFLOW  = 2'd1,
        FLT_UNDERFLOW = 2'd2
    } fault_t;
endpackage

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: bounded LIFO of return addresses; caller guarantees no push when full or pop when empty
module return_stack #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    // sized to a power of two so ptr-1 always indexes in range, even when empty
    logic [W-1:0]  mem [2**DW];
    logic [DW-1:0] ptr;
    always_ff @(posedge clk)
        if (push) mem[ptr] <= din;
    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (push) ptr <= ptr + DW'(1);
        else if (pop) ptr <= ptr - DW'(1);
    end
    assign top   = mem[ptr - DW'(1)];
    assign depth = ptr;
    assign full  = ptr == DW'(DEPTH);
    assign empty = ptr == '0;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address register with branch/jump/call/return, return stack, stall and halt/fault FSM
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] count,
    output logic [DW-1:0]     depth,
    output logic              halted,
    output logic [1:0]        fault
);
    pc_state_t         state, state_n;
    fault_t            flt, flt_n;
    logic [ADDR_W-1:0] count_n, top, ret_addr;
    logic              push, pop, full, empty, active;
    assign active   = state == ST_RUN && !stall;
    assign ret_addr = count + ADDR_W'(1);
    always_comb begin
        count_n = count;
        state_n = state;
        flt_n   = flt;
        push    = 1'b0;
        pop     = 1'b0;
        if (active) begin
            case (op)
                OP_BR_REL:  count_n = count + target;
                OP_JMP_ABS: count_n = target;
                OP_CALL: begin
                    state_n = full ? ST_FAULT : state;
                    flt_n   = full ? FLT_OVERFLOW : flt;
                    push    = !full;
                    count_n = full ? count : target;
                end
                OP_RET: begin
                    state_n = empty ? ST_FAULT : state;
                    flt_n   = empty ? FLT_UNDERFLOW : flt;
                    pop     = !empty;
                    count_n = empty ? count : top;
                end
                OP_HALT:    state_n = ST_HALTED;
                default:    count_n = ret_addr;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_ADDR;
            state <= ST_RUN;
            flt   <= FLT_NONE;
        end else begin
            count <= count_n;
            state <= state_n;
            flt   <= flt_n;
        end
    end
    return_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .top   (top),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );
    assign halted = state != ST_RUN;
    assign fault  = flt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed checks of pc_sequencer plus hand-written halt and reset/stall sequences
module tb_pc_sequencer;
    import pc_pkg::*;
    typedef struct {
        logic       r;
        logic       s;
        logic [2:0] op;
        logic [7:0] tgt;
        logic [7:0] cnt;
        logic [2:0] dep;
        logic       h;
        logic [1:0] f;
    } vec_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] target = 8'd0;
    logic [7:0] count;
    logic [2:0] depth;
    logic       halted;
    logic [1:0] fault;
    int         errors = 0;
    int         checks = 0;
    vec_t       vq[$];
    pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall),
        .op     (op),
        .target (target),
        .count  (count),
        .depth  (depth),
        .halted (halted),
        .fault  (fault)
    );
    always #5 clk = ~clk;
    function automatic void v(input logic r, input logic s, input logic [2:0] o, input logic [7:0] t,
                              input logic [7:0] c, input logic [2:0] d, input logic h, input logic [1:0] f);
        vq.push_back('{r, s, o, t, c, d, h, f});
    endfunction
    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask
    task automatic chk_all(input int idx, input logic [7:0] c, input logic [2:0] d, input logic h, input logic [1:0] f);
        chk("count", idx, count, c);
        chk("depth", idx, {5'd0, depth}, {5'd0, d});
        chk("halted", idx, {7'd0, halted}, {7'd0, h});
        chk("fault", idx, {6'd0, fault}, {6'd0, f});
    endtask
    initial begin
        // reset, sequential steps, relative branches
        v(1, 0, OP_NEXT, 8'h00, 8'h00, 0, 0, FLT_NONE);
        for (int i = 1; i <= 5; i++) v(0, 0, OP_NEXT, 8'h00, 8'(i), 0, 0, FLT_NONE);
        for (int i = 0; i < 5; i++) v(0, 0, OP_BR_REL, 8'h04, 8'(9 + 4 * i), 0, 0, FLT_NONE);
        // wrap-around
        v(0, 0, OP_JMP_ABS, 8'hFE, 8'hFE, 0, 0, FLT_NONE);
        v(0, 0, OP_NEXT, 8'h00, 8'hFF, 0, 0, FLT_NONE);
        v(0, 0, OP_NEXT, 8'h00, 8'h00, 0, 0, FLT_NONE);
        v(0, 0, OP_NEXT, 8'h00, 8'h01, 0, 0, FLT_NONE);
        v(0, 0, 3'd6, 8'h00, 8'h02, 0, 0, FLT_NONE);
        v(0, 0, OP_BR_REL, 8'hFC, 8'hFE, 0, 0, FLT_NONE);
        v(0, 0, 3'd7, 8'h00, 8'hFF, 0, 0, FLT_NONE);
        // nested calls, back-to-back call/ret, wrapped return address
        v(0, 0, OP_JMP_ABS, 8'h10, 8'h10, 0, 0, FLT_NONE);
        v(0, 0, OP_CALL, 8'h40, 8'h40, 1, 0, FLT_NONE);
        v(0, 0, OP_CALL, 8'h80, 8'h80, 2, 0, FLT_NONE);
        v(0, 0, OP_RET, 8'h00, 8'h41, 1, 0, FLT_NONE);
        v(0, 0, OP_RET, 8'h00, 8'h11, 0, 0, FLT_NONE);
        v(0, 0, OP_CALL, 8'h30, 8'h30, 1, 0, FLT_NONE);
        v(0, 0, OP_RET, 8'h00, 8'h12, 0, 0, FLT_NONE);
        v(0, 0, OP_JMP_ABS, 8'hFF, 8'hFF, 0, 0, FLT_NONE);
        v(0, 0, OP_CALL, 8'h50, 8'h50, 1, 0, FLT_NONE);
        v(0, 1, OP_RET, 8'h00, 8'h50, 1, 0, FLT_NONE);
        v(0, 0, OP_RET, 8'h00, 8'h00, 0, 0, FLT_NONE);
        // overflow
        v(1, 0, OP_NEXT, 8'h00, 8'h00, 0, 0, FLT_NONE);
        for (int i = 1; i <= 4; i++) v(0, 0, OP_CALL, 8'h20, 8'h20, 3'(i), 0, FLT_NONE);
        v(0, 0, OP_CALL, 8'h20, 8'h20, 4, 1, FLT_OVERFLOW);
        v(0, 0, OP_NEXT, 8'h00, 8'h20, 4, 1, FLT_OVERFLOW);
        v(0, 0, OP_RET, 8'h00, 8'h20, 4, 1, FLT_OVERFLOW);
        v(0, 0, OP_JMP_ABS, 8'h99, 8'h20, 4, 1, FLT_OVERFLOW);
        v(1, 0, OP_RET, 8'h00, 8'h00, 0, 0, FLT_NONE);
        // underflow
        v(0, 0, OP_JMP_ABS, 8'h07, 8'h07, 0, 0, FLT_NONE);
        v(0, 0, OP_RET, 8'h00, 8'h07, 0, 1, FLT_UNDERFLOW);
        v(0, 0, OP_NEXT, 8'h00, 8'h07, 0, 1, FLT_UNDERFLOW);
        v(1, 0, OP_NEXT, 8'h00, 8'h00, 0, 0, FLT_NONE);
        // reset with a non-empty stack really empties it
        v(0, 0, OP_CALL, 8'h33, 8'h33, 1, 0, FLT_NONE);
        v(1, 0, OP_NEXT, 8'h00, 8'h00, 0, 0, FLT_NONE);
        v(0, 0, OP_RET, 8'h00, 8'h00, 0, 1, FLT_UNDERFLOW);
        v(1, 0, OP_NEXT, 8'h00, 8'h00, 0, 0, FLT_NONE);
        // stall then release, then halt
        for (int i = 0; i < 3; i++) v(0, 1, OP_JMP_ABS, 8'h55, 8'h00, 0, 0, FLT_NONE);
        v(0, 0, OP_JMP_ABS, 8'h55, 8'h55, 0, 0, FLT_NONE);
        v(0, 0, OP_HALT, 8'h00, 8'h55, 0, 1, FLT_NONE);
        foreach (vq[i]) begin
            reset = vq[i].r;
            stall = vq[i].s;
            op = vq[i].op;
            target = vq[i].tgt;
            @(posedge clk);
            #1;
            chk_all(i, vq[i].cnt, vq[i].dep, vq[i].h, vq[i].f);
        end
        // halted: ten cycles of mixed ops and stall must change nothing
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            op = 3'(i % 6);
            stall = i[0];
            target = 8'(i * 17 + 3);
            @(posedge clk);
            #1;
            chk_all(100 + i, 8'h55, 0, 1, FLT_NONE);
        end
        // reset beats stall, and the sequencer runs again afterwards
        reset = 1'b1;
        stall = 1'b1;
        op = OP_JMP_ABS;
        target = 8'h77;
        @(posedge clk);
        #1;
        chk_all(200, 8'h00, 0, 0, FLT_NONE);
        reset = 1'b0;
        stall = 1'b0;
        op = OP_NEXT;
        @(posedge clk);
        #1;
        chk_all(201, 8'h01, 0, 0, FLT_NONE);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
